// File: rtl/csel_cla_pkg.sv
// csel_cla_pkg
// Shared constants for the 8-bit carry-select / carry-lookahead adder.
//   WIDTH : operand and sum width (the adder supports 8 only)
//   BLK   : carry-lookahead block width (two blocks make up WIDTH)
package csel_cla_pkg;
    localparam int WIDTH = 8;
    localparam int BLK   = 4;
endpackage

// File: rtl/cla_4bit.sv
// cla_4bit
// 4-bit carry-lookahead adder block. Every internal carry comes from the
// flattened generate/propagate equations on ci, so no ripple chain exists.
// Ports:
//   a, b : 4-bit operands
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
//   c3   : carry into bit 3 (used by the top level for signed overflow)
module cla_4bit
    import csel_cla_pkg::*;
(
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           ci,
    output logic [BLK-1:0] s,
    output logic           co,
    output logic           c3
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic           c1;
    logic           c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/csel_cla_adder_8.sv
// csel_cla_adder_8
// 8-bit carry-select adder with a single output register stage.
// The low nibble is summed by one CLA block; the high nibble is summed
// twice in parallel (carry-in 0 and carry-in 1) and the low-block carry
// picks the correct result. Latency is one cycle, one result per cycle.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : operands valid this cycle
//   a, b      : unsigned 8-bit operands
//   cin       : carry in
//   out_valid : registered in_valid
//   sum       : registered (a+b+cin)[7:0], held while in_valid is low
//   cout      : registered (a+b+cin)[8],   held while in_valid is low
//   ovf       : registered signed overflow (only with CSEL_CLA_OVERFLOW_EN)
// Build option:
//   CSEL_CLA_OVERFLOW_EN : adds the ovf output port.
module csel_cla_adder_8
    import csel_cla_pkg::*;
#(
    parameter int WIDTH_P = WIDTH,
    parameter int BLK_P   = BLK
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
`ifdef CSEL_CLA_OVERFLOW_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    generate
        if (WIDTH_P != 8 || BLK_P != 4) begin : g_bad_width
            $error("csel_cla_adder_8: only WIDTH=8 with BLK=4 is supported");
        end
    endgenerate

    logic [BLK-1:0] s_lo;
    logic [BLK-1:0] s_hi0;
    logic [BLK-1:0] s_hi1;
    logic           c4;
    logic           co_hi0;
    logic           co_hi1;
    logic           c7_hi0;
    logic           c7_hi1;
    logic           unused_c3_lo;

    cla_4bit u_lo (
        .a  (a[BLK-1:0]),
        .b  (b[BLK-1:0]),
        .ci (cin),
        .s  (s_lo),
        .co (c4),
        .c3 (unused_c3_lo)
    );

    cla_4bit u_hi_c0 (
        .a  (a[WIDTH-1:BLK]),
        .b  (b[WIDTH-1:BLK]),
        .ci (1'b0),
        .s  (s_hi0),
        .co (co_hi0),
        .c3 (c7_hi0)
    );

    cla_4bit u_hi_c1 (
        .a  (a[WIDTH-1:BLK]),
        .b  (b[WIDTH-1:BLK]),
        .ci (1'b1),
        .s  (s_hi1),
        .co (co_hi1),
        .c3 (c7_hi1)
    );

    logic [WIDTH-1:0] sum_next;
    logic             cout_next;
    logic             c7_sel;

    // Carry-select: the low-block carry-out chooses which precomputed
    // upper half is correct.
    assign sum_next  = {(c4 ? s_hi1 : s_hi0), s_lo};
    assign cout_next = c4 ? co_hi1 : co_hi0;
    assign c7_sel    = c4 ? c7_hi1 : c7_hi0;

`ifdef CSEL_CLA_OVERFLOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                cout <= cout_next;
                ovf  <= c7_sel ^ cout_next;
            end
        end
    end
`else
    logic unused_c7_sel;
    assign unused_c7_sel = c7_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_next;
                cout <= cout_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csel_cla_adder_8.sv
// tb_csel_cla_adder_8
// Self-checking bench for csel_cla_adder_8: an arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_csel_cla_adder_8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic [7:0] sum;
    logic       cout;
`ifdef CSEL_CLA_OVERFLOW_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    csel_cla_adder_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
`ifdef CSEL_CLA_OVERFLOW_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, registered once.
    int m_res;
    bit m_valid;
    bit m_ovf;

    function automatic int ref_sum(input logic [7:0] x, input logic [7:0] y,
                                   input logic c);
        return int'(x) + int'(y) + int'(c);
    endfunction

    function automatic bit ref_ovf(input logic [7:0] x, input logic [7:0] y,
                                   input logic c);
        int r;
        r = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (r > 127) || (r < -128);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_res   <= 0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            m_valid <= in_valid;
            if (in_valid) begin
                m_res <= ref_sum(a, b, cin);
                m_ovf <= ref_ovf(a, b, cin);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        chk("model_out_valid", int'(out_valid), int'(m_valid));
        chk("model_sum",       int'(sum),       m_res & 255);
        chk("model_cout",      int'(cout),      (m_res >> 8) & 1);
`ifdef CSEL_CLA_OVERFLOW_EN
        chk("model_ovf",       int'(ovf),       int'(m_ovf));
`endif
    end

    // Directed vector with literal expectations, checked 1 ns after capture.
    task automatic vec(input string name, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input int es, input int ec, input int eo);
        @(negedge clk);
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        @(posedge clk);
        #1;
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_sum"},   int'(sum),       es);
        chk({name, "_cout"},  int'(cout),      ec);
`ifdef CSEL_CLA_OVERFLOW_EN
        chk({name, "_ovf"},   int'(ovf),       eo);
`else
        if (eo < 0) $display("note: negative ovf expectation in %s", name);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        a = 8'd0;
        b = 8'd0;
        cin = 1'b0;
        #1;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_sum",   int'(sum),       0);
        chk("reset_cout",  int'(cout),      0);
        #22;
        rst = 1'b0;

        vec("v_2_5",      8'd2,   8'd5,   1'b0, 7,   0, 0);
        vec("v_1_1",      8'd1,   8'd1,   1'b0, 2,   0, 0);
        vec("v_20_20_c",  8'd20,  8'd20,  1'b1, 41,  0, 0);
        vec("v_75_75_c",  8'd75,  8'd75,  1'b1, 151, 0, 1);
        vec("v_128_128",  8'd128, 8'd128, 1'b0, 0,   1, 1);
        vec("v_200_20",   8'd200, 8'd20,  1'b0, 220, 0, 0);
        vec("v_255_0_c",  8'd255, 8'd0,   1'b1, 0,   1, 0);
        vec("v_15_1",     8'd15,  8'd1,   1'b0, 16,  0, 0);
        vec("v_0_0",      8'd0,   8'd0,   1'b0, 0,   0, 0);
        vec("v_255_255_c",8'd255, 8'd255, 1'b1, 255, 1, 0);

        // Hold while in_valid is low: result from 255+255+1 must remain.
        idle(3);
        @(posedge clk);
        #1;
        chk("hold_valid", int'(out_valid), 0);
        chk("hold_sum",   int'(sum),       255);
        chk("hold_cout",  int'(cout),      1);

        // Mid-stream reset discards in-flight data, asynchronously.
        vec("pre_rst",    8'd255, 8'd255, 1'b1, 255, 1, 0);
        @(negedge clk);
        a = 8'd9;
        b = 8'd9;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_sum",   int'(sum),       0);
        chk("async_rst_cout",  int'(cout),      0);
        @(posedge clk);
        #1;
        chk("held_rst_sum",    int'(sum),       0);
        chk("held_rst_valid",  int'(out_valid), 0);
        #2;
        rst = 1'b0;
        vec("post_rst_3_4", 8'd3, 8'd4, 1'b0, 7, 0, 0);

        // Structured sweep: every a and cin against 16 spread b values.
        for (int ia = 0; ia < 256; ia++) begin
            for (int k = 0; k < 16; k++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    @(negedge clk);
                    in_valid = 1'b1;
                    a = 8'(ia);
                    b = 8'((k * 17 + ia) & 255);
                    cin = 1'(ic);
                end
            end
        end

        // Random operands with random in_valid gaps.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            cin = 1'($urandom_range(0, 1));
        end

        idle(2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
